// File: rtl/gf2mz_unload.sv
`default_nettype none
// ============================================================================
// Module   : gf2mz_unload
// Purpose  : Streams the n-coefficient GF(2^m)[z] product out of the
//            synchronous-read result RAM on a valid/ready interface.
// Options  : GF2MZ_UNLOAD_CKSUM_EN appends an XOR-checksum beat.
// Revision : 1.0  initial release
// ============================================================================
module gf2mz_unload #(
   parameter int n  = 47,
   parameter int m  = 101,
   parameter int AW = $clog2(n)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          mem_rd_en,
   output logic [AW-1:0] mem_addr,
   input  logic [m-1:0]  mem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [m-1:0]  out_data,
   output logic          out_last
);

   localparam int CW = $clog2(n + 2);
`ifdef GF2MZ_UNLOAD_CKSUM_EN
   localparam int NBEATS = n + 1;
`else
   localparam int NBEATS = n;
`endif
   localparam logic [AW-1:0] LAST_ADDR = AW'(n - 1);
   localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] beat_cnt;
   logic          in_flight;
   logic [1:0]    fifo_cnt;
   logic [1:0]    occupancy;
   logic [m-1:0]  slot0;
   logic [m-1:0]  slot1;
   logic          accept;
   logic          pop;
   logic          fifo_pop;
   logic          head_valid;
   logic [m-1:0]  head_data;

   assign accept    = (state == IDLE) && start;
   assign occupancy = fifo_cnt + {1'b0, in_flight};
   assign mem_rd_en = (state == READ) && (occupancy < 2'd2);
   assign mem_addr  = rd_ptr;
   assign busy      = (state == READ) || (state == DRAIN);
   assign done      = (state == DONE);

   // An empty FIFO forwards the word arriving from the RAM in the same cycle,
   // so the first beat appears one cycle after its read.
   assign head_valid = (fifo_cnt != 2'd0) || in_flight;
   assign head_data  = (fifo_cnt != 2'd0) ? slot0 : (in_flight ? mem_rdata : '0);
   assign fifo_pop   = head_valid && out_ready;
   assign pop        = out_valid && out_ready;
   assign out_last   = out_valid && (beat_cnt == LAST_BEAT);

`ifdef GF2MZ_UNLOAD_CKSUM_EN
   logic [m-1:0] acc;
   logic         cksum_beat;

   // All coefficients have left the FIFO once beat_cnt reaches n.
   assign cksum_beat = (state == DRAIN) && (beat_cnt == CW'(n));
   assign out_valid  = head_valid || cksum_beat;
   assign out_data   = cksum_beat ? acc : head_data;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         acc <= '0;
      end else if (accept) begin
         acc <= '0;
      end else if (in_flight) begin
         acc <= acc ^ mem_rdata;
      end
   end
`else
   assign out_valid = head_valid;
   assign out_data  = head_data;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (mem_rd_en && (rd_ptr == LAST_ADDR)) state_nxt = DRAIN;
         DRAIN:   if (pop && out_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rd_ptr    <= '0;
         beat_cnt  <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= mem_rd_en;
         if (accept) begin
            rd_ptr   <= '0;
            beat_cnt <= '0;
         end else begin
            if (mem_rd_en) begin
               rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
            end
            if (pop) begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end
      end
   end

   // Two-entry skid FIFO; the read-issue rule keeps fifo_cnt + in_flight <= 2.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fifo_cnt <= 2'd0;
         slot0    <= '0;
         slot1    <= '0;
      end else begin
         case (fifo_cnt)
            2'd0: begin
               if (in_flight && !fifo_pop) begin
                  slot0    <= mem_rdata;
                  fifo_cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (in_flight && fifo_pop) begin
                  slot0 <= mem_rdata;
               end else if (in_flight) begin
                  slot1    <= mem_rdata;
                  fifo_cnt <= 2'd2;
               end else if (fifo_pop) begin
                  fifo_cnt <= 2'd0;
               end
            end
            default: begin
               if (fifo_pop) begin
                  slot0 <= slot1;
                  if (in_flight) begin
                     slot1 <= mem_rdata;
                  end else begin
                     fifo_cnt <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gf2mz_unload.sv
`default_nettype none
// Directed testbench for gf2mz_unload: RAM model, ready patterns, restart,
// mid-burst reset and all-ones data, checked with immediate assertions.
module tb_gf2mz_unload;

   localparam int N    = 47;
   localparam int M    = 101;
   localparam int AWID = 6;
`ifdef GF2MZ_UNLOAD_CKSUM_EN
   localparam int NB       = N + 1;
   localparam int DONE_CYC = 50;
`else
   localparam int NB       = N;
   localparam int DONE_CYC = 49;
`endif

   logic            clk = 1'b0;
   logic            rst_b;
   logic            start;
   logic            busy;
   logic            done;
   logic            mem_rd_en;
   logic [AWID-1:0] mem_addr;
   logic [M-1:0]    mem_rdata;
   logic            out_valid;
   logic            out_ready;
   logic [M-1:0]    out_data;
   logic            out_last;

   logic [M-1:0]    mem [0:63];
   logic [M-1:0]    exp_beats [$];

   int vectors     = 0;
   int miscompares = 0;

   gf2mz_unload dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   task automatic chk_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs == exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int pat, input int t);
      case (pat)
         1:       return (((t - 1) % 4) == 0) || (((t - 1) % 4) == 3);
         2:       return t > 10;
         default: return 1'b1;
      endcase
   endfunction

   task automatic build_expected();
      logic [M-1:0] x;
      x = '0;
      exp_beats.delete();
      for (int i = 0; i < N; i++) begin
         exp_beats.push_back(mem[i]);
         x = x ^ mem[i];
      end
`ifdef GF2MZ_UNLOAD_CKSUM_EN
      exp_beats.push_back(x);
`endif
   endtask

   // Runs one unload; cycle t is the cycle after edge t-1, start sampled at edge 0.
   task automatic unload(input int pat, input int kick_beat, input int abort_beat, input bit timing);
      int           nbeats      = 0;
      int           ndone       = 0;
      int           done_cyc    = -1;
      int           first_valid = -1;
      int           reads_pre   = 0;
      int           nlast       = 0;
      int           last_idx    = -1;
      int           max_addr    = 0;
      int           bad_rd      = 0;
      bit           kicked      = 1'b0;
      bit           pv          = 1'b0;
      bit           pr          = 1'b0;
      logic [M-1:0] pd          = '0;
      logic [M-1:0] got [$];
      @(negedge clk);
      start     = 1'b1;
      out_ready = rdy(pat, 0);
      for (int t = 1; t <= 400; t++) begin
         @(negedge clk);
         start = 1'b0;
         if (kick_beat >= 0 && !kicked && nbeats == kick_beat) begin
            start  = 1'b1;
            kicked = 1'b1;
         end
         out_ready = rdy(pat, t);
         if (pv && !pr) begin
            chk_int("hold_valid", int'(out_valid), 1);
            chk_vec("hold_data", 128'(out_data), 128'(pd));
         end
         if (mem_rd_en) begin
            if (nbeats == 0) reads_pre++;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
            if (!busy) bad_rd++;
         end
         if (out_valid && first_valid < 0) first_valid = t;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            if (out_last) begin
               nlast++;
               last_idx = nbeats;
            end
            nbeats++;
         end
         if (done) begin
            ndone++;
            if (done_cyc < 0) done_cyc = t;
         end
         pv = out_valid;
         pr = out_ready;
         pd = out_data;
         if (abort_beat >= 0 && nbeats == abort_beat) begin
            for (int i = 0; i < nbeats; i++) chk_vec($sformatf("abort_beat%0d", i), 128'(got[i]), 128'(exp_beats[i]));
            return;
         end
         if (done_cyc >= 0 && t >= done_cyc + 4) break;
      end
      chk_int("done_count", ndone, 1);
      chk_int("beat_count", nbeats, NB);
      for (int i = 0; i < NB && i < nbeats; i++) chk_vec($sformatf("beat%0d", i), 128'(got[i]), 128'(exp_beats[i]));
      chk_int("last_count", nlast, 1);
      chk_int("last_index", last_idx, NB - 1);
      chk_int("addr_in_range", int'(max_addr <= N - 1), 1);
      chk_int("rd_en_outside_busy", bad_rd, 0);
      if (timing) begin
         chk_int("first_valid_cycle", first_valid, 2);
         chk_int("done_cycle", done_cyc, DONE_CYC);
      end
      if (pat == 2) chk_int("reads_before_handshake_le2", int'(reads_pre <= 2), 1);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = '0;
      rst_b     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_vec("reset_outputs",
              128'({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last}), '0);
      rst_b = 1'b1;

      for (int i = 0; i < N; i++) mem[i] = M'(i + 1);
      build_expected();
      unload(0, -1, -1, 1'b1);
      unload(1, -1, -1, 1'b0);
      unload(2, -1, -1, 1'b0);
      unload(0, 20, -1, 1'b1);

      unload(0, -1, 30, 1'b0);
      rst_b = 1'b0;
      #1;
      chk_vec("async_reset_outputs",
              128'({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last}), '0);
      @(negedge clk);
      chk_vec("reset_hold_outputs",
              128'({busy, done, mem_rd_en, mem_addr, out_valid, out_data, out_last}), '0);
      rst_b = 1'b1;
      unload(0, -1, -1, 1'b1);

      for (int i = 0; i < N; i++) mem[i] = '1;
      build_expected();
      unload(0, -1, -1, 1'b1);
      unload(1, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
